// File: rtl/dot_product_sweep_ctrl.sv
// Sparse local-field update sweep sequencer: scans J row groups, skips groups
// with no flipped spin, aligns masks to row data and tracks datapath completion.
module dot_product_sweep_ctrl #(
    parameter int unsigned NUM_ROWS_PER_CLK = 4,
    parameter int unsigned NUM_ROWS         = 16,
    parameter int unsigned MEM_LATENCY      = 1,
    parameter int unsigned TIMEOUT          = 64,
    localparam int unsigned NUM_GROUPS = (NUM_ROWS + NUM_ROWS_PER_CLK - 1) / NUM_ROWS_PER_CLK,
    localparam int unsigned GAW        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        clear_first,
    input  logic [NUM_ROWS-1:0]         flip_mask,
    input  logic [NUM_ROWS-1:0]         sigma_new,
    output logic                        busy,
    output logic                        sweep_done,
    output logic                        timeout_err,
    output logic [GAW:0]                groups_issued,
    output logic                        row_rd_en,
    output logic [GAW-1:0]              row_rd_addr,
    output logic                        dp_clear,
    output logic [NUM_ROWS_PER_CLK-1:0] dp_rows_valid,
    output logic [NUM_ROWS_PER_CLK-1:0] dp_sigma_bits,
    input  logic                        dp_done
);

    localparam int unsigned P     = NUM_ROWS_PER_CLK;
    localparam int unsigned PAD_W = NUM_GROUPS * P;
    localparam int unsigned OW    = GAW + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state, state_d;
    logic [GAW-1:0]      grp, grp_d;
    logic [NUM_ROWS-1:0] flip_q, sigma_q;
    logic [PAD_W-1:0]    flip_pad, sigma_pad;
    logic [P-1:0]        mask_d, slice_d, mask_q, slice_q;
    logic                rd_en_d, tmo_d, accept, pipe_busy, done_eff;
    logic [OW-1:0]       outstanding;
    logic [TW-1:0]       tcnt;
    logic [P-1:0]        pipe_m [MEM_LATENCY];
    logic [P-1:0]        pipe_s [MEM_LATENCY];

    assign dp_rows_valid = pipe_m[MEM_LATENCY-1];
    assign dp_sigma_bits = pipe_s[MEM_LATENCY-1];

    // Next state, next scanned group and the mask of that group.
    always_comb begin
        state_d   = state;
        grp_d     = grp;
        tmo_d     = 1'b0;
        accept    = (state == S_IDLE) && start;
        done_eff  = dp_done && (outstanding != '0);
        pipe_busy = 1'b0;
        for (int i = 0; i < int'(MEM_LATENCY); i++) begin
            pipe_busy = pipe_busy | (|pipe_m[i]);
        end
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = clear_first ? S_CLEAR : S_ISSUE;
                    grp_d   = '0;
                end
            end
            S_CLEAR: state_d = S_ISSUE;
            S_ISSUE: begin
                if (grp == GAW'(NUM_GROUPS - 1)) state_d = S_DRAIN;
                else                             grp_d   = grp + GAW'(1);
            end
            S_DRAIN: begin
                if (!pipe_busy && (outstanding == '0)) begin
                    state_d = S_DONE;
                end else if (!dp_done && (tcnt == TW'(TIMEOUT - 1))) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // The first group is scanned in the same edge that latches the inputs.
        flip_pad  = PAD_W'((state == S_IDLE) ? flip_mask : flip_q);
        sigma_pad = PAD_W'((state == S_IDLE) ? sigma_new : sigma_q);
        mask_d    = flip_pad[grp_d*P +: P];
        slice_d   = sigma_pad[grp_d*P +: P];
        rd_en_d   = (state_d == S_ISSUE) && (|mask_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            grp           <= '0;
            flip_q        <= '0;
            sigma_q       <= '0;
            mask_q        <= '0;
            slice_q       <= '0;
            outstanding   <= '0;
            tcnt          <= '0;
            busy          <= 1'b0;
            sweep_done    <= 1'b0;
            timeout_err   <= 1'b0;
            groups_issued <= '0;
            row_rd_en     <= 1'b0;
            row_rd_addr   <= '0;
            dp_clear      <= 1'b0;
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                pipe_m[i] <= '0;
                pipe_s[i] <= '0;
            end
        end else begin
            state       <= state_d;
            grp         <= grp_d;
            busy        <= (state_d == S_CLEAR) || (state_d == S_ISSUE) || (state_d == S_DRAIN);
            dp_clear    <= (state_d == S_CLEAR);
            sweep_done  <= (state_d == S_DONE);
            timeout_err <= tmo_d;
            row_rd_en   <= rd_en_d;
            row_rd_addr <= rd_en_d ? grp_d : '0;
            mask_q      <= rd_en_d ? mask_d : '0;
            slice_q     <= rd_en_d ? slice_d : '0;
            if (accept) begin
                flip_q  <= flip_mask;
                sigma_q <= sigma_new;
            end

            // Alignment pipeline: stage 0 captures the group read this cycle.
            pipe_m[0] <= mask_q;
            pipe_s[0] <= slice_q;
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                pipe_m[i] <= pipe_m[i-1];
                pipe_s[i] <= pipe_s[i-1];
            end

            if (accept || tmo_d)          outstanding <= '0;
            else if (row_rd_en && !done_eff) outstanding <= outstanding + OW'(1);
            else if (!row_rd_en && done_eff) outstanding <= outstanding - OW'(1);

            if (accept)         groups_issued <= '0;
            else if (row_rd_en) groups_issued <= groups_issued + OW'(1);

            if ((state != S_DRAIN) || dp_done) tcnt <= '0;
            else                               tcnt <= tcnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_dot_product_sweep_ctrl.sv
// Bench for dot_product_sweep_ctrl: vector table of sweeps with a read/alignment
// scoreboard, plus hand sequences for NUM_ROWS=10 and reset during a sweep.
module tb_dot_product_sweep_ctrl;

    localparam int unsigned GAW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b0;
    logic           start = 1'b0, clear_first = 1'b0;
    logic [15:0]    flip_mask = '0, sigma_new = '0;
    logic           busy, sweep_done, timeout_err, row_rd_en, dp_clear, dp_done;
    logic [GAW:0]   groups_issued;
    logic [GAW-1:0] row_rd_addr;
    logic [3:0]     dp_rows_valid, dp_sigma_bits;

    logic           start_10 = 1'b0, clear_first_10 = 1'b0;
    logic [9:0]     flip_10 = '0, sigma_10 = '0;
    logic           busy_10, sweep_done_10, timeout_err_10, row_rd_en_10, dp_clear_10, dp_done_10;
    logic [GAW:0]   groups_issued_10;
    logic [GAW-1:0] row_rd_addr_10;
    logic [3:0]     dp_rows_valid_10, dp_sigma_bits_10;

    dot_product_sweep_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear_first(clear_first),
        .flip_mask(flip_mask), .sigma_new(sigma_new), .busy(busy),
        .sweep_done(sweep_done), .timeout_err(timeout_err), .groups_issued(groups_issued),
        .row_rd_en(row_rd_en), .row_rd_addr(row_rd_addr), .dp_clear(dp_clear),
        .dp_rows_valid(dp_rows_valid), .dp_sigma_bits(dp_sigma_bits), .dp_done(dp_done)
    );

    dot_product_sweep_ctrl #(.NUM_ROWS(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .start(start_10), .clear_first(clear_first_10),
        .flip_mask(flip_10), .sigma_new(sigma_10), .busy(busy_10),
        .sweep_done(sweep_done_10), .timeout_err(timeout_err_10), .groups_issued(groups_issued_10),
        .row_rd_en(row_rd_en_10), .row_rd_addr(row_rd_addr_10), .dp_clear(dp_clear_10),
        .dp_rows_valid(dp_rows_valid_10), .dp_sigma_bits(dp_sigma_bits_10), .dp_done(dp_done_10)
    );

    // Datapath models: dp_done two cycles after each valid group, optionally withheld.
    logic       withhold = 1'b0;
    logic [1:0] dv = '0, dv_10 = '0;
    always @(posedge clk) begin
        dv    <= {dv[0], (dp_rows_valid != 4'd0) && !withhold};
        dv_10 <= {dv_10[0], (dp_rows_valid_10 != 4'd0)};
    end
    assign dp_done    = dv[1];
    assign dp_done_10 = dv_10[1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [GAW-1:0] addr;
        logic [3:0]     m;
        logic [3:0]     s;
    } rd_t;
    rd_t exp_q[$];

    // Scoreboard: every read pops an expected group; valid/sigma must follow one cycle later.
    logic       mon_en = 1'b0;
    logic       prev_rd = 1'b0;
    logic [3:0] prev_m = '0, prev_s = '0, em, es;
    rd_t        e;
    always @(negedge clk) begin
        if (mon_en) begin
            em = prev_rd ? prev_m : 4'd0;
            es = prev_rd ? prev_s : 4'd0;
            if (em != 4'd0 || dp_rows_valid != 4'd0 || dp_sigma_bits != 4'd0) begin
                check("dp_rows_valid", 32'(dp_rows_valid), 32'(em));
                check("dp_sigma_bits", 32'(dp_sigma_bits), 32'(es));
            end
            prev_rd = 1'b0;
            if (row_rd_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read", 32'(row_rd_addr) + 32'd100, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("row_rd_addr", 32'(row_rd_addr), 32'(e.addr));
                    prev_rd = 1'b1;
                    prev_m  = e.m;
                    prev_s  = e.s;
                end
            end
        end else begin
            prev_rd = 1'b0;
        end
    end

    typedef struct {
        logic        cf;
        logic [15:0] flip;
        logic [15:0] sig;
        logic        hold;
        int          groups;
        int          busy_cycles;
    } vec_t;
    vec_t tbl[7];

    task automatic run_sweep(input vec_t v);
        int busy_cnt = 0, clear_cnt = 0, clear_cyc = 0, first_rd = 0, last_rd = 0;
        int done_cnt = 0, tmo_cnt = 0, tmo_cyc = 0;
        bit fin = 1'b0;
        logic [15:0] f = v.flip, s = v.sig;
        withhold = v.hold;
        for (int g = 0; g < 4; g++) begin
            if (f[g*4 +: 4] != 4'd0) exp_q.push_back('{addr: GAW'(g), m: f[g*4 +: 4], s: s[g*4 +: 4]});
        end
        @(negedge clk);
        start = 1'b1; clear_first = v.cf; flip_mask = f; sigma_new = s;
        @(posedge clk);
        #1;
        start = 1'b0; flip_mask = ~f; sigma_new = ~s;
        for (int k = 1; k <= 200 && !fin; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (dp_clear) begin clear_cnt++; clear_cyc = k; end
            if (row_rd_en) begin
                if (first_rd == 0) first_rd = k;
                last_rd = k;
            end
            if (sweep_done) begin done_cnt++; fin = 1'b1; end
            if (timeout_err) begin tmo_cnt++; tmo_cyc = k; fin = 1'b1; end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (sweep_done) done_cnt++;
            if (timeout_err) tmo_cnt++;
        end
        check("sweep_finished", 32'(fin), 32'd1);
        check("groups_issued", 32'(groups_issued), 32'(v.groups));
        check("busy_cycles", 32'(busy_cnt), 32'(v.busy_cycles));
        if (v.hold) begin
            check("timeout_err_count", 32'(tmo_cnt), 32'd1);
            check("no_sweep_done", 32'(done_cnt), 32'd0);
            check("timeout_latency", 32'(tmo_cyc), 32'(last_rd + 65));
        end else begin
            check("sweep_done_count", 32'(done_cnt), 32'd1);
            check("no_timeout_err", 32'(tmo_cnt), 32'd0);
        end
        if (v.cf) begin
            check("dp_clear_cycles", 32'(clear_cnt), 32'd1);
            check("read_after_clear", 32'(first_rd), 32'(clear_cyc + 1));
        end else begin
            check("dp_clear_cycles", 32'(clear_cnt), 32'd0);
        end
        check("reads_pending", 32'(exp_q.size()), 32'd0);
        withhold = 1'b0;
    endtask

    function automatic logic [31:0] outs16();
        return 32'({busy, sweep_done, timeout_err, groups_issued, row_rd_en, row_rd_addr,
                    dp_clear, dp_rows_valid, dp_sigma_bits});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nrd, pulses;
        logic [GAW-1:0] last_addr;
        logic [3:0] last_v, last_s;
        bit fin10;

        tbl[0] = '{cf: 1'b0, flip: 16'hFFFF, sig: 16'hA5A5, hold: 1'b0, groups: 4, busy_cycles: 8};
        tbl[1] = '{cf: 1'b0, flip: 16'h0030, sig: 16'hA5A5, hold: 1'b0, groups: 1, busy_cycles: 6};
        tbl[2] = '{cf: 1'b0, flip: 16'h0000, sig: 16'hFFFF, hold: 1'b0, groups: 0, busy_cycles: 5};
        tbl[3] = '{cf: 1'b1, flip: 16'hFFFF, sig: 16'h1234, hold: 1'b0, groups: 4, busy_cycles: 9};
        tbl[4] = '{cf: 1'b0, flip: 16'h8001, sig: 16'h7F3C, hold: 1'b0, groups: 2, busy_cycles: 8};
        tbl[5] = '{cf: 1'b0, flip: 16'hFFFF, sig: 16'hA5A5, hold: 1'b1, groups: 4, busy_cycles: 68};
        tbl[6] = '{cf: 1'b0, flip: 16'hFFFF, sig: 16'hA5A5, hold: 1'b0, groups: 4, busy_cycles: 8};

        repeat (3) @(negedge clk);
        check("reset_outputs", outs16(), 32'd0);
        check("reset_outputs_10", 32'({busy_10, sweep_done_10, timeout_err_10, groups_issued_10,
              row_rd_en_10, dp_clear_10, dp_rows_valid_10, dp_sigma_bits_10}), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_sweep(tbl[i]);
            repeat (2) @(negedge clk);
        end

        // NUM_ROWS=10: the last group has only two real rows.
        nrd = 0; last_addr = '0; last_v = '0; last_s = '0; fin10 = 1'b0;
        @(negedge clk);
        start_10 = 1'b1; flip_10 = 10'h3FF; sigma_10 = 10'h2A5;
        @(posedge clk);
        #1;
        start_10 = 1'b0;
        for (int k = 0; k < 100 && !fin10; k++) begin
            @(negedge clk);
            if (row_rd_en_10) begin nrd++; last_addr = row_rd_addr_10; end
            if (dp_rows_valid_10 != 4'd0) begin last_v = dp_rows_valid_10; last_s = dp_sigma_bits_10; end
            if (sweep_done_10) fin10 = 1'b1;
        end
        check("rows10_done", 32'(fin10), 32'd1);
        check("rows10_reads", 32'(nrd), 32'd3);
        check("rows10_last_addr", 32'(last_addr), 32'd2);
        check("rows10_last_valid", 32'(last_v), 32'h3);
        check("rows10_last_sigma", 32'(last_s), 32'h2);
        check("rows10_groups", 32'(groups_issued_10), 32'd3);

        // Reset while issuing abandons the sweep silently.
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        start = 1'b1; clear_first = 1'b0; flip_mask = 16'hFFFF; sigma_new = 16'h5A5A;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("issuing_before_reset", 32'(row_rd_en), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_sweep", outs16(), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (sweep_done || timeout_err || busy) pulses++;
        end
        check("no_pulse_after_reset", 32'(pulses), 32'd0);
        mon_en = 1'b1;
        run_sweep(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
